// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the sync_fifo_flex family.
package fifo_pkg;

  localparam int unsigned DEF_DATA_W = 16;
  localparam int unsigned DEF_DEPTH  = 16;

  // Which requests were accepted on a given edge: {read, write}.
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_PUSH = 2'b01,
    OP_POP  = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

  function automatic int unsigned addr_w(input int unsigned depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// 1W/1R storage for sync_fifo_flex; registered read by default, async read when
// SYNC_FIFO_FWFT_EN is defined.
module sync_fifo_mem
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned DEPTH  = DEF_DEPTH,
  parameter int unsigned ADDR_W = addr_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  logic unused_ok;
  assign unused_ok = ^{re, rst_n};
  assign rdata     = mem[raddr];
`else
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] rdata_d;

  always_comb begin
    rdata_d = rdata_q;
    if (re) begin
      rdata_d = mem[raddr];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;
`endif

endmodule

// File: rtl/sync_fifo_flex.sv
// Single-clock parametrised FIFO with registered flags, fill level and sticky errors.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through read behaviour.
module sync_fifo_flex
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_W    = DEF_DATA_W,
  parameter int unsigned DEPTH     = DEF_DEPTH,
  parameter int unsigned AFULL_TH  = DEPTH - 2,
  parameter int unsigned AEMPTY_TH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rd_en,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     rd_valid,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow,
  input  logic                     clr_err
);

  localparam int unsigned ADDR_W = addr_w(DEPTH);
  localparam logic [ADDR_W:0] ONE      = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0] AFULL_C  = AFULL_TH[ADDR_W:0];
  localparam logic [ADDR_W:0] AEMPTY_C = AEMPTY_TH[ADDR_W:0];

  logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic              afull_q, afull_d;
  logic              aempty_q, aempty_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;
  logic              wr_acc, rd_acc;
  fifo_op_e          op;
  logic [DATA_W-1:0] mem_rdata;

  always_comb begin
    wr_acc   = wr_en && !full_q;
    rd_acc   = rd_en && !empty_q;
    op       = fifo_op_e'({rd_acc, wr_acc});
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    case (op)
      OP_PUSH: begin
        wr_ptr_d = wr_ptr_q + ONE;
        count_d  = count_q + ONE;
      end
      OP_POP: begin
        rd_ptr_d = rd_ptr_q + ONE;
        count_d  = count_q - ONE;
      end
      OP_BOTH: begin
        wr_ptr_d = wr_ptr_q + ONE;
        rd_ptr_d = rd_ptr_q + ONE;
      end
      default: ;
    endcase

    // Flags derive from next-state pointers so they update on the same edge.
    empty_d  = (wr_ptr_d == rd_ptr_d);
    full_d   = (wr_ptr_d[ADDR_W] != rd_ptr_d[ADDR_W]) &&
               (wr_ptr_d[ADDR_W-1:0] == rd_ptr_d[ADDR_W-1:0]);
    afull_d  = (count_d >= AFULL_C);
    aempty_d = (count_d <= AEMPTY_C);

    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (clr_err) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
    if (wr_en && full_q) begin
      overflow_d = 1'b1;
    end
    if (rd_en && empty_q) begin
      underflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      afull_q     <= 1'b0;
      aempty_q    <= 1'b1;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      full_q      <= full_d;
      empty_q     <= empty_d;
      afull_q     <= afull_d;
      aempty_q    <= aempty_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  sync_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (wr_acc),
    .waddr (wr_ptr_q[ADDR_W-1:0]),
    .wdata (wr_data),
    .re    (rd_acc),
    .raddr (rd_ptr_q[ADDR_W-1:0]),
    .rdata (mem_rdata)
  );

`ifdef SYNC_FIFO_FWFT_EN
  // Head word is shown straight from the array; masked while empty so the
  // output reads zero out of reset.
  assign rd_data  = empty_q ? '0 : mem_rdata;
  assign rd_valid = !empty_q;
`else
  logic rd_valid_q, rd_valid_d;

  always_comb begin
    rd_valid_d = rd_acc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_valid_d;
    end
  end

  assign rd_data  = mem_rdata;
  assign rd_valid = rd_valid_q;
`endif

  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = afull_q;
  assign almost_empty = aempty_q;
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule
